// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - consumer-side Tuse/Tnew hazard, forwarding and HI/LO busy controller
module hazard_scoreboard #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       d_md_start,
    input  logic       d_md_div,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       md_busy
);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_E  = 2'b01;
    localparam logic [1:0] SEL_M  = 2'b10;
    localparam logic [1:0] SEL_W  = 2'b11;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [4:0]       e_wa;
    logic [1:0]       e_tnew;
    logic [4:0]       e_rs;
    logic [4:0]       e_rt;
    logic             e_md_start;
    logic             e_md_div;
    logic [4:0]       m_wa;
    logic [1:0]       m_tnew;
    logic [4:0]       w_wa;
    logic [CNT_W-1:0] cnt;

    logic             hazard_rs;
    logic             hazard_rt;
    logic             md_stall;

    // Youngest in-flight writer decides; an E match hides any older M match.
    function automatic logic reg_hazard(
        input logic [4:0] a,
        input logic [1:0] tuse,
        input logic [4:0] ewa,
        input logic [1:0] etn,
        input logic [4:0] mwa,
        input logic [1:0] mtn
    );
        logic h;
        h = 1'b0;
        if (a != 5'd0 && tuse != TUSE_NONE) begin
            if (ewa == a)
                h = (etn > tuse);
            else if (mwa == a)
                h = (mtn > tuse);
        end
        return h;
    endfunction

    function automatic logic [1:0] d_fwd(
        input logic [4:0] a,
        input logic [4:0] ewa,
        input logic [1:0] etn,
        input logic [4:0] mwa,
        input logic [1:0] mtn,
        input logic [4:0] wwa
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (a != 5'd0) begin
            if (ewa == a)
                sel = (etn == 2'd0) ? SEL_E : SEL_RF;
            else if (mwa == a)
                sel = (mtn == 2'd0) ? SEL_M : SEL_RF;
            else if (wwa == a)
                sel = SEL_W;
        end
        return sel;
    endfunction

    function automatic logic [1:0] e_fwd(
        input logic [4:0] a,
        input logic [4:0] mwa,
        input logic [1:0] mtn,
        input logic [4:0] wwa
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (a != 5'd0) begin
            if (mwa == a && mtn == 2'd0)
                sel = SEL_M;
            else if (wwa == a)
                sel = SEL_W;
        end
        return sel;
    endfunction

    always_comb begin
        hazard_rs = reg_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
        hazard_rt = reg_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
        md_busy   = (cnt != '0);
        md_stall  = d_md_use & (e_md_start | md_busy);
        stall     = hazard_rs | hazard_rt | md_stall;
        fwd_d_rs  = d_fwd(d_rs, e_wa, e_tnew, m_wa, m_tnew, w_wa);
        fwd_d_rt  = d_fwd(d_rt, e_wa, e_tnew, m_wa, m_tnew, w_wa);
        fwd_e_rs  = e_fwd(e_rs, m_wa, m_tnew, w_wa);
        fwd_e_rt  = e_fwd(e_rt, m_wa, m_tnew, w_wa);
    end

    // E stage: capture the D instruction, or a bubble when stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_wa       <= 5'd0;
            e_tnew     <= 2'd0;
            e_rs       <= 5'd0;
            e_rt       <= 5'd0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
        end else if (stall) begin
            e_wa       <= 5'd0;
            e_tnew     <= 2'd0;
            e_rs       <= 5'd0;
            e_rt       <= 5'd0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
        end else begin
            e_wa       <= d_wa;
            e_tnew     <= d_tnew;
            e_rs       <= d_rs;
            e_rt       <= d_rt;
            e_md_start <= d_md_start;
            e_md_div   <= d_md_div;
        end
    end

    // M and W age unconditionally; Tnew saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wa   <= 5'd0;
            m_tnew <= 2'd0;
            w_wa   <= 5'd0;
        end else begin
            m_wa   <= e_wa;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            w_wa   <= m_wa;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (e_md_start)
            cnt <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_use, d_md_start, d_md_div;
    logic       stall, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_wa       (d_wa),
        .d_tnew     (d_tnew),
        .d_md_use   (d_md_use),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .stall      (stall),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .md_busy    (md_busy)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tu_rs;
        logic [1:0] tu_rt;
        logic [4:0] wa;
        logic [1:0] tn;
        logic       use_md;
        logic       st;
        logic       dv;
    } stim_t;

    // Observed vector: {stall, md_busy, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}
    logic [9:0] obs;
    assign obs = {stall, md_busy, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};

    logic [9:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                                 input logic [4:0] wa, input logic [1:0] tn,
                                 input logic u, input logic st, input logic dv);
        stim_t s;
        s.rs = rs; s.rt = rt; s.tu_rs = tu_rs; s.tu_rt = tu_rt;
        s.wa = wa; s.tn = tn; s.use_md = u; s.st = st; s.dv = dv;
        return s;
    endfunction

    function automatic logic [9:0] ex(input logic st, input logic bz,
                                      input logic [1:0] drs, input logic [1:0] drt,
                                      input logic [1:0] ers, input logic [1:0] ert);
        return {st, bz, drs, drt, ers, ert};
    endfunction

    task automatic set_inputs(input stim_t s);
        d_rs = s.rs; d_rt = s.rt; d_tuse_rs = s.tu_rs; d_tuse_rt = s.tu_rt;
        d_wa = s.wa; d_tnew = s.tn; d_md_use = s.use_md;
        d_md_start = s.st; d_md_div = s.dv;
    endtask

    task automatic apply(input stim_t s);
        @(negedge clk);
        set_inputs(s);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_inputs(mk(0, 0, 3, 3, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] x;
        reset = 1'b1;
        set_inputs(mk(0, 0, 3, 3, 0, 0, 0, 0, 0));
        #1;
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0));
        x = exp_q.pop_front();
        checks++;
        if (obs !== x) begin
            errors++;
            $display("FAIL reset_held got %b exp %b", obs, x);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0));
        x = exp_q.pop_front();
        checks++;
        if (obs !== x) begin
            errors++;
            $display("FAIL reset_released got %b exp %b", obs, x);
        end
    endtask

    // lw $1 ; add $2,$1,$1 ; or $3,$1,$0
    task automatic test_load_use();
        stim_t s[4];
        logic [9:0] e[4];
        logic [9:0] x;
        do_reset();
        s[0] = mk(0, 0, 3, 3, 1, 2, 0, 0, 0); e[0] = ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[1] = mk(1, 1, 1, 1, 2, 1, 0, 0, 0); e[1] = ex(1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[2] = s[1];                          e[2] = ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[3] = mk(1, 0, 1, 3, 3, 1, 0, 0, 0); e[3] = ex(0, 0, 2'b11, 2'b00, 2'b11, 2'b11);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e[i]);
            apply(s[i]);
            x = exp_q.pop_front();
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL load_use step %0d got %b exp %b", i, obs, x);
            end
        end
    endtask

    // ori $3 ; beq $3,$3 ; idle
    task automatic test_alu_branch();
        stim_t s[4];
        logic [9:0] e[4];
        logic [9:0] x;
        do_reset();
        s[0] = mk(0, 0, 3, 3, 3, 1, 0, 0, 0); e[0] = ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[1] = mk(3, 3, 0, 0, 0, 0, 0, 0, 0); e[1] = ex(1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[2] = s[1];                          e[2] = ex(0, 0, 2'b10, 2'b10, 2'b00, 2'b00);
        s[3] = mk(0, 0, 3, 3, 0, 0, 0, 0, 0); e[3] = ex(0, 0, 2'b00, 2'b00, 2'b11, 2'b11);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e[i]);
            apply(s[i]);
            x = exp_q.pop_front();
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL alu_branch step %0d got %b exp %b", i, obs, x);
            end
        end
    endtask

    task automatic test_zero_reg();
        stim_t s;
        logic [9:0] x;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            s = (i == 0) ? mk(0, 0, 3, 3, 0, 2, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
            exp_q.push_back(ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
            apply(s);
            x = exp_q.pop_front();
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL zero_reg step %0d got %b exp %b", i, obs, x);
            end
        end
    endtask

    // mult/div followed by mflo: stall held n+1 cycles
    task automatic test_md_interlock(input logic dv, input int n);
        stim_t s;
        logic [9:0] x;
        logic st_e, bz_e;
        do_reset();
        for (int i = 0; i <= n + 2; i++) begin
            s    = (i == 0) ? mk(0, 0, 3, 3, 0, 0, 1, 1, dv) : mk(0, 0, 3, 3, 8, 1, 1, 0, 0);
            st_e = (i >= 1) && (i <= n + 1);
            bz_e = (i >= 2) && (i <= n + 1);
            exp_q.push_back(ex(st_e, bz_e, 2'b00, 2'b00, 2'b00, 2'b00));
            apply(s);
            x = exp_q.pop_front();
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL md_interlock div=%0b step %0d got %b exp %b", dv, i, obs, x);
            end
        end
    endtask

    // Async reset while a div is counting (cnt = 7) with E/M/W occupied.
    task automatic test_reset_mid_div();
        stim_t s[6];
        logic [9:0] e[6];
        logic [9:0] x;
        do_reset();
        s[0] = mk(0, 0, 3, 3, 0, 0, 1, 1, 1); e[0] = ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[1] = mk(0, 0, 3, 3, 5, 1, 0, 0, 0); e[1] = ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[2] = mk(0, 0, 3, 3, 6, 1, 0, 0, 0); e[2] = ex(0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        s[3] = mk(0, 0, 3, 3, 7, 1, 0, 0, 0); e[3] = ex(0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        s[4] = mk(0, 0, 3, 3, 8, 0, 0, 0, 0); e[4] = ex(0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        s[5] = mk(8, 7, 1, 1, 0, 0, 1, 0, 0); e[5] = ex(1, 1, 2'b01, 2'b10, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(e[i]);
            apply(s[i]);
            x = exp_q.pop_front();
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL reset_mid_div step %0d got %b exp %b", i, obs, x);
            end
        end
        reset = 1'b1;
        #1;
        exp_q.push_back(ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        x = exp_q.pop_front();
        checks++;
        if (obs !== x) begin
            errors++;
            $display("FAIL reset_mid_div async got %b exp %b", obs, x);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.push_back(ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
        x = exp_q.pop_front();
        checks++;
        if (obs !== x) begin
            errors++;
            $display("FAIL reset_mid_div after got %b exp %b", obs, x);
        end
    endtask

    // Two back-to-back writers of $4: the younger (E) wins, then M feeds E.
    task automatic test_e_over_m();
        stim_t s[4];
        logic [9:0] e[4];
        logic [9:0] x;
        do_reset();
        s[0] = mk(0, 0, 3, 3, 4, 0, 0, 0, 0); e[0] = ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[1] = mk(0, 0, 3, 3, 4, 0, 0, 0, 0); e[1] = ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[2] = mk(4, 4, 0, 0, 0, 0, 0, 0, 0); e[2] = ex(0, 0, 2'b01, 2'b01, 2'b00, 2'b00);
        s[3] = s[2];                          e[3] = ex(0, 0, 2'b10, 2'b10, 2'b10, 2'b10);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e[i]);
            apply(s[i]);
            x = exp_q.pop_front();
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL e_over_m step %0d got %b exp %b", i, obs, x);
            end
        end
    endtask

    // Tnew 2 against Tuse 0: two back-to-back stalls, rt unused never stalls.
    task automatic test_back_to_back();
        stim_t s[4];
        logic [9:0] e[4];
        logic [9:0] x;
        do_reset();
        s[0] = mk(0, 0, 3, 3, 9, 2, 0, 0, 0); e[0] = ex(0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[1] = mk(9, 9, 0, 3, 0, 0, 0, 0, 0); e[1] = ex(1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[2] = s[1];                          e[2] = ex(1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        s[3] = s[1];                          e[3] = ex(0, 0, 2'b11, 2'b11, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e[i]);
            apply(s[i]);
            x = exp_q.pop_front();
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL back_to_back step %0d got %b exp %b", i, obs, x);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_branch();
        test_zero_reg();
        test_md_interlock(1'b0, 5);
        test_md_interlock(1'b1, 10);
        test_reset_mid_div();
        test_e_over_m();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer-side hazard controller for the 5-stage MIPS pipeline (P6).
- Per-stage producer timing (Tnew, computed at decode) enters here as a data input.
- The block tracks in-flight destinations through E/M/W, ages their Tnew each cycle, and compares against the D-stage Tuse.
- Outputs: D-stage stall, D- and E-stage forwarding selects, and a HI/LO multiply/divide busy interlock.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start
CNT_W, 4, width of busy counter (must hold DIV_CYCLES)

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous active-high reset
d_rs  input  5  D-stage rs address
d_rt  input  5  D-stage rt address
d_tuse_rs  input  2  cycles until D instr needs rs (0/1/2; 3 = not used)
d_tuse_rt  input  2  same for rt
d_wa  input  5  D-stage destination register (0 = none)
d_tnew  input  2  producer Tnew of D instr as it will enter E (0..2)
d_md_use  input  1  D instr reads/writes HI/LO or starts mult/div
d_md_start  input  1  D instr is mult/multu/div/divu
d_md_div  input  1  with d_md_start: 1 = div, 0 = mult
stall  output  1  freeze PC and F/D; insert bubble into E
fwd_d_rs  output  2  D rs source: 00 RF, 01 E, 10 M, 11 W
fwd_d_rt  output  2  same for rt
fwd_e_rs  output  2  E rs source: 00 reg, 10 M, 11 W (01 unused)
fwd_e_rt  output  2  same for rt
md_busy  output  1  mult/div unit busy

Behaviour:
- State: E entry {wa, tnew, rs, rt, md_start, md_div}; M entry {wa, tnew}; W entry {wa}; busy counter cnt.
- Reset (async, any time, including mid-mult/div): all wa = 0, all tnew = 0, E rs/rt = 0, E md_start = 0, cnt = 0.
- Reset output values: stall = 0, md_busy = 0, all fwd = 00.
- Posedge, stall = 0: E <= {d_wa, d_tnew, d_rs, d_rt, d_md_start, d_md_div}.
- Posedge, stall = 1: E <= bubble (wa = 0, tnew = 0, rs = rt = 0, md_start = 0).
- Posedge, always:
  - M.wa <= E.wa; M.tnew <= E.tnew - 1, saturating at 0.
  - W.wa <= M.wa (tnew at W is 0 by definition).
- Register hazard, rs (rt identical):
  - Condition: d_rs != 0 and d_tuse_rs != 3.
  - Stall if (E.wa == d_rs and E.tnew > d_tuse_rs), else if (M.wa == d_rs and M.tnew > d_tuse_rs).
  - Youngest match decides: an E match masks M.
- D forwarding, rs (rt identical; combinational):
  - d_rs == 0 -> 00.
  - Else first match among E (with E.tnew == 0) -> 01, M (with M.tnew == 0) -> 10, W -> 11.
  - No match -> 00.
  - A matching E/M entry with tnew != 0 stops the search -> 00; the stall covers that case.
- E forwarding: E.rs vs M (M.tnew == 0) -> 10, else W -> 11, else 00. Register 0 never forwards.
- MD interlock:
  - Posedge with E.md_start = 1: cnt <= DIV_CYCLES if E.md_div else MULT_CYCLES.
  - Else if cnt != 0: cnt <= cnt - 1.
  - md_busy = (cnt != 0).
  - Stall if d_md_use and (E.md_start or md_busy).
- stall = OR of the rs hazard, rt hazard and MD interlock; purely combinational from current state and D inputs.
- Same-cycle events:
  - A stall bubble and an aging M/W update in the same cycle are independent.
  - A new start cannot arrive while busy, because the interlock stalls it.

Test Plan:
- lw $1 then add $2,$1,$1 (d_tnew = 2, tuse = 1): stall = 1 for exactly 1 cycle. The next cycle has M.tnew = 1 > 1 false, so stall = 0. The cycle after, fwd_d_rs = 11 from W.
- ori $3 then beq $3 (tnew = 1, tuse = 0): stall 1 cycle, then fwd_d_rs = 10 (M, tnew 0).
- addu $0 writer followed by a $0 reader: stall = 0 and fwd = 00 in every cycle.
- mult followed by mflo on the next instruction: stall held 1 + 5 = 6 cycles, release when cnt reaches 0. For div the hold is 11 cycles.
- Assert reset at cnt = 7 during a div with E full: md_busy, stall, all wa and fwd return to 0 immediately, without waiting for clk.
- E and M both write $4 (E.tnew = 0, M.tnew = 0), D reads $4: fwd_d_rs = 01 (E wins).
